// File: rtl/ip_tx_rr_sched.sv
// Packet-locked 4:1 round-robin TLP scheduler with post-packet drain gap and grant timeout.
// Latency: grant one cycle after a request is sampled in IDLE; data/ready paths are combinational.
// Backpressure: tx_rdy is steered to the granted source only; a grant unserviced for c_TIMEOUT cycles is aborted.
module ip_tx_rr_sched #(
    parameter int c_DATA_WIDTH = 64,
    parameter int c_DRAIN      = 2,
    parameter int c_TIMEOUT    = 1024
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    tx_val,
    input  logic [3:0]              tx_req_i,
    input  logic [c_DATA_WIDTH-1:0] tx_din_0,
    input  logic [c_DATA_WIDTH-1:0] tx_din_1,
    input  logic [c_DATA_WIDTH-1:0] tx_din_2,
    input  logic [c_DATA_WIDTH-1:0] tx_din_3,
    input  logic [3:0]              tx_sop_i,
    input  logic [3:0]              tx_eop_i,
    input  logic [3:0]              tx_dwen_i,
    output logic [3:0]              tx_rdy_o,
    output logic                    tx_req,
    output logic [c_DATA_WIDTH-1:0] tx_dout,
    output logic                    tx_sop,
    output logic                    tx_eop,
    output logic                    tx_dwen,
    input  logic                    tx_rdy,
    output logic [1:0]              gnt,
    output logic                    gnt_vld,
    output logic                    timeout_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_XFER  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic [15:0] TO_LAST = 16'(c_TIMEOUT - 1);
    localparam logic [3:0]  DR_LAST = 4'(c_DRAIN - 1);

    logic [1:0]  state_q, state_d;
    logic [1:0]  gnt_q, gnt_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [15:0] wait_q, wait_d;
    logic [3:0]  drain_q, drain_d;
    logic        terr_q, terr_d;

    logic [1:0]  pick;
    logic [1:0]  idx;
    logic        sel_req;
    logic        sel_eop;

    assign sel_req = tx_req_i[gnt_q];
    assign sel_eop = tx_eop_i[gnt_q];

    // Round-robin search: scan ptr+3 down to ptr so the lowest offset from ptr wins.
    always_comb begin
        pick = ptr_q;
        idx  = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr_q + 2'(i);
            if (tx_req_i[idx]) begin
                pick = idx;
            end
        end
    end

    // Next-state logic: grant, hold for the whole packet, drain, and abort stale grants.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        wait_d  = wait_q;
        drain_d = drain_q;
        terr_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (tx_val && (tx_req_i != 4'b0000)) begin
                    gnt_d   = pick;
                    wait_d  = 16'd0;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                if (!sel_req) begin
                    // Source withdrew before its first beat: release and move priority on.
                    state_d = S_IDLE;
                    ptr_d   = gnt_q + 2'd1;
                end else if (tx_rdy && sel_eop) begin
                    state_d = S_DRAIN;
                    ptr_d   = gnt_q + 2'd1;
                    drain_d = 4'd0;
                end else if (tx_rdy) begin
                    state_d = S_XFER;
                end else if (wait_q == TO_LAST) begin
                    state_d = S_IDLE;
                    terr_d  = 1'b1;
                    ptr_d   = gnt_q + 2'd1;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            S_XFER: begin
                // Once the first beat has moved the packet is committed; stalls never time out.
                if (tx_rdy && sel_eop) begin
                    state_d = S_DRAIN;
                    ptr_d   = gnt_q + 2'd1;
                    drain_d = 4'd0;
                end
            end
            S_DRAIN: begin
                if (drain_q == DR_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    drain_d = drain_q + 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset discards any in-flight packet.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            gnt_q   <= 2'd0;
            ptr_q   <= 2'd0;
            wait_q  <= 16'd0;
            drain_q <= 4'd0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            wait_q  <= wait_d;
            drain_q <= drain_d;
            terr_q  <= terr_d;
        end
    end

    assign gnt_vld     = (state_q == S_GRANT) || (state_q == S_XFER);
    assign gnt         = gnt_q;
    assign timeout_err = terr_q;

    // Combinational datapath steered by the current grant; control is gated outside GRANT/XFER.
    always_comb begin
        case (gnt_q)
            2'd1:    tx_dout = tx_din_1;
            2'd2:    tx_dout = tx_din_2;
            2'd3:    tx_dout = tx_din_3;
            default: tx_dout = tx_din_0;
        endcase
        tx_req   = 1'b0;
        tx_sop   = 1'b0;
        tx_eop   = 1'b0;
        tx_dwen  = 1'b0;
        tx_rdy_o = 4'b0000;
        if (gnt_vld) begin
            tx_req          = sel_req;
            tx_sop          = tx_sop_i[gnt_q];
            tx_eop          = sel_eop;
            tx_dwen         = tx_dwen_i[gnt_q];
            tx_rdy_o[gnt_q] = tx_rdy;
        end
    end

endmodule

// File: tb/tb_ip_tx_rr_sched.sv
// Directed bench for ip_tx_rr_sched: source models drive packets, expected beats/aborts go to a scoreboard.
// Stimulus runs at posedge+2, source models advance at posedge+1, the monitor samples at negedge.
// Cycle-exact checks are interleaved with stimulus; beat contents are checked by the monitor.
module tb_ip_tx_rr_sched;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        tx_val;
    logic        tx_rdy;
    logic [3:0]  tx_req_i, tx_sop_i, tx_eop_i, tx_dwen_i;
    logic [63:0] tx_din_0, tx_din_1, tx_din_2, tx_din_3;
    logic [3:0]  tx_rdy_o;
    logic        tx_req, tx_sop, tx_eop, tx_dwen;
    logic [63:0] tx_dout;
    logic [1:0]  gnt;
    logic        gnt_vld;
    logic        timeout_err;

    always #5 clk = ~clk;

    ip_tx_rr_sched #(.c_DATA_WIDTH(64), .c_DRAIN(2), .c_TIMEOUT(8)) dut (
        .clk(clk), .rstn(rstn), .tx_val(tx_val), .tx_req_i(tx_req_i),
        .tx_din_0(tx_din_0), .tx_din_1(tx_din_1), .tx_din_2(tx_din_2), .tx_din_3(tx_din_3),
        .tx_sop_i(tx_sop_i), .tx_eop_i(tx_eop_i), .tx_dwen_i(tx_dwen_i),
        .tx_rdy_o(tx_rdy_o), .tx_req(tx_req), .tx_dout(tx_dout),
        .tx_sop(tx_sop), .tx_eop(tx_eop), .tx_dwen(tx_dwen), .tx_rdy(tx_rdy),
        .gnt(gnt), .gnt_vld(gnt_vld), .timeout_err(timeout_err)
    );

    typedef struct packed {
        logic        to;
        logic [1:0]  g;
        logic [63:0] d;
        logic        s;
        logic        e;
        logic        w;
        logic [3:0]  ro;
    } exp_t;

    exp_t        sbq[$];
    int          n_vec = 0;
    int          n_miss = 0;
    int          beats_seen = 0;

    // Source model state
    bit          act[4];
    bit          rep[4];
    int          len[4];
    int          bc[4];
    logic [15:0] tag;
    logic [3:0]  fire;

    function automatic logic [63:0] mkdat(input int n, input int b);
        return {tag, 14'd0, 2'(n), 32'(b)};
    endfunction

    task automatic chk(input string nm, input logic [79:0] a, input logic [79:0] e);
        n_vec++;
        if (a !== e) begin
            n_miss++;
            $display("FAIL %s: got %h want %h", nm, a, e);
        end
    endtask

    task automatic upd();
        for (int n = 0; n < 4; n++) begin
            tx_req_i[n]  = act[n];
            tx_sop_i[n]  = (bc[n] == 0);
            tx_eop_i[n]  = (bc[n] == len[n] - 1);
            tx_dwen_i[n] = 1'(bc[n] % 2);
        end
        tx_din_0 = mkdat(0, bc[0]);
        tx_din_1 = mkdat(1, bc[1]);
        tx_din_2 = mkdat(2, bc[2]);
        tx_din_3 = mkdat(3, bc[3]);
    endtask

    task automatic push_beat(input int n, input int b, input int l);
        exp_t x;
        x.to = 1'b0;
        x.g  = 2'(n);
        x.d  = mkdat(n, b);
        x.s  = (b == 0);
        x.e  = (b == l - 1);
        x.w  = 1'(b % 2);
        x.ro = 4'(1 << n);
        sbq.push_back(x);
    endtask

    task automatic push_to(input int n);
        exp_t x;
        x    = '0;
        x.to = 1'b1;
        x.g  = 2'(n);
        sbq.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_ctl"}, 80'({gnt_vld, gnt, tx_req, tx_sop, tx_eop, tx_dwen, tx_rdy_o, timeout_err}), 80'(0));
        chk({nm, "_dout"}, 80'(tx_dout), 80'(tx_din_0));
    endtask

    task automatic wait_pops(input int target, input int budget);
        int k;
        k = 0;
        while (beats_seen < target && k < budget) begin
            tick();
            k++;
        end
        chk("beats_within_budget", 80'(beats_seen >= target), 80'(1));
    endtask

    // Source models advance after each edge on beats accepted at that edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int n = 0; n < 4; n++) begin
                if (fire[n]) begin
                    if (bc[n] == len[n] - 1) begin
                        bc[n] = 0;
                        if (!rep[n]) act[n] = 1'b0;
                    end else begin
                        bc[n] = bc[n] + 1;
                    end
                end
            end
            upd();
        end
    end

    // Monitor: every accepted beat or timeout pulse is popped from the scoreboard and compared.
    initial begin
        exp_t a;
        exp_t e;
        forever begin
            @(negedge clk);
            fire = (rstn && tx_rdy) ? tx_rdy_o : 4'b0000;
            if (rstn && ((gnt_vld && tx_rdy && tx_req) || timeout_err)) begin
                a = '0;
                a.to = timeout_err;
                a.g  = gnt;
                if (!timeout_err) begin
                    a.d  = tx_dout;
                    a.s  = tx_sop;
                    a.e  = tx_eop;
                    a.w  = tx_dwen;
                    a.ro = tx_rdy_o;
                    beats_seen++;
                end
                if (sbq.size() == 0) begin
                    chk("unexpected_output", 80'(a), 80'(0));
                end else begin
                    e = sbq.pop_front();
                    chk("sb_event", 80'(a), 80'(e));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    initial begin
        tx_val = 1'b0;
        tx_rdy = 1'b0;
        tag    = 16'h0;
        fire   = 4'b0;
        for (int n = 0; n < 4; n++) begin
            act[n] = 1'b0; rep[n] = 1'b0; len[n] = 1; bc[n] = 0;
        end
        upd();

        // Reset values
        #12;
        chk_reset("reset");
        @(posedge clk);
        #2;
        rstn = 1'b1;
        tick();

        // Fairness: all sources continuously request single-beat packets
        tag = 16'h0001; tx_val = 1'b1; tx_rdy = 1'b1;
        push_beat(0, 0, 1); push_beat(1, 0, 1); push_beat(2, 0, 1);
        push_beat(3, 0, 1); push_beat(0, 0, 1);
        for (int n = 0; n < 4; n++) begin act[n] = 1'b1; rep[n] = 1'b1; len[n] = 1; end
        upd();
        wait_pops(5, 60);
        for (int n = 0; n < 4; n++) begin act[n] = 1'b0; rep[n] = 1'b0; end
        upd();
        repeat (4) begin
            tick();
            chk("fair_no_extra_grant", 80'(gnt_vld), 80'(0));
        end

        // Single source 2, three beats; source 0 arrives during drain
        tag = 16'h0002; len[2] = 3;
        push_beat(2, 0, 3); push_beat(2, 1, 3); push_beat(2, 2, 3);
        act[2] = 1'b1; upd();
        tick();
        chk("single_grant", 80'({gnt_vld, gnt, tx_req, tx_rdy_o}), 80'({1'b1, 2'd2, 1'b1, 4'b0100}));
        chk("single_dout0", 80'(tx_dout), 80'(mkdat(2, 0)));
        tick(); tick(); tick();
        chk("drain1_idle_out", 80'({gnt_vld, tx_req, tx_rdy_o}), 80'(0));
        len[0] = 1; act[0] = 1'b1; push_beat(0, 0, 1); upd();
        tick();
        chk("drain2_idle_out", 80'({gnt_vld, tx_req, tx_rdy_o}), 80'(0));
        tick();
        chk("post_drain_idle", 80'({gnt_vld, tx_req}), 80'(0));
        tick();
        chk("next_grant_src0", 80'({gnt_vld, gnt, tx_req}), 80'({1'b1, 2'd0, 1'b1}));
        tick(); tick(); tick();

        // Stall: source 1, four beats, tx_rdy low for five cycles mid-packet
        tag = 16'h0003; len[1] = 4;
        push_beat(1, 0, 4); push_beat(1, 1, 4); push_beat(1, 2, 4); push_beat(1, 3, 4);
        act[1] = 1'b1; upd();
        tick(); tick(); tick();
        tx_rdy = 1'b0;
        repeat (5) begin
            tick();
            chk("stall_hold", 80'({gnt_vld, gnt, timeout_err, tx_rdy_o}), 80'({1'b1, 2'd1, 1'b0, 4'b0000}));
        end
        tx_rdy = 1'b1;
        tick(); tick();
        chk("stall_eop_drain", 80'({gnt_vld, timeout_err}), 80'(0));
        tick(); tick();

        // Timeout: source 3 granted and never serviced, source 0 waiting
        tag = 16'h0004; tx_rdy = 1'b0; len[3] = 1; len[0] = 1;
        act[3] = 1'b1; act[0] = 1'b1; upd();
        push_to(3); push_beat(0, 0, 1);
        tick();
        chk("to_grant3", 80'({gnt_vld, gnt, tx_req, timeout_err}), 80'({1'b1, 2'd3, 1'b1, 1'b0}));
        repeat (7) begin
            tick();
            chk("to_waiting", 80'({gnt_vld, timeout_err}), 80'({1'b1, 1'b0}));
        end
        tick();
        chk("to_pulse", 80'({gnt_vld, timeout_err}), 80'({1'b0, 1'b1}));
        tick();
        chk("to_regrant0", 80'({gnt_vld, gnt, timeout_err}), 80'({1'b1, 2'd0, 1'b0}));
        act[3] = 1'b0; tx_rdy = 1'b1; upd();
        tick(); tick(); tick();

        // Gating: tx_val low blocks grants
        tag = 16'h0005; tx_val = 1'b0; act[1] = 1'b1; act[2] = 1'b1; upd();
        repeat (4) begin
            tick();
            chk("gated_no_grant", 80'({gnt_vld, tx_req}), 80'(0));
        end
        act[1] = 1'b0; act[2] = 1'b0; upd();

        // Withdraw: source 0 drops its request while granted
        tx_val = 1'b1; tx_rdy = 1'b0; act[0] = 1'b1; upd();
        tick();
        chk("wd_grant0", 80'({gnt_vld, gnt}), 80'({1'b1, 2'd0}));
        act[0] = 1'b0; upd();
        tick();
        chk("wd_idle", 80'({gnt_vld, timeout_err}), 80'(0));
        for (int n = 0; n < 4; n++) begin act[n] = 1'b1; len[n] = 1; end
        tx_rdy = 1'b1; push_beat(1, 0, 1); upd();
        tick();
        chk("wd_ptr_next1", 80'({gnt_vld, gnt}), 80'({1'b1, 2'd1}));
        act[0] = 1'b0; act[2] = 1'b0; act[3] = 1'b0; upd();
        tick(); tick(); tick();

        // Asynchronous reset during beat 2 of a four-beat packet
        tag = 16'h0006; len[2] = 4;
        push_beat(2, 0, 4); push_beat(2, 1, 4);
        act[2] = 1'b1; upd();
        tick(); tick(); tick();
        chk("pre_reset_xfer", 80'({gnt_vld, gnt, tx_sop}), 80'({1'b1, 2'd2, 1'b0}));
        rstn = 1'b0;
        #1;
        chk_reset("reset_mid");
        act[2] = 1'b0; bc[2] = 0; upd();
        tick();
        rstn = 1'b1;
        tick();
        chk("post_release", 80'({gnt_vld, gnt, timeout_err}), 80'(0));
        for (int n = 0; n < 4; n++) begin act[n] = 1'b1; len[n] = 1; bc[n] = 0; end
        push_beat(0, 0, 1); upd();
        tick();
        chk("post_reset_ptr0", 80'({gnt_vld, gnt}), 80'({1'b1, 2'd0}));
        act[1] = 1'b0; act[2] = 1'b0; act[3] = 1'b0; upd();
        tick(); tick(); tick();

        chk("sb_empty", 80'(sbq.size()), 80'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/ip_tx_rr_sched.md
# ip_tx_rr_sched

Four-port, packet-locked round-robin scheduler for the PCIe transmit TLP path. It sits between four TLP sources and the single core transmit interface. It grants one source at a time, holds the grant for the whole packet (sop to eop), enforces a drain gap after each packet, and rotates priority fairly. It also aborts grants that the core never services within a timeout.

## Interface

- c_DATA_WIDTH, 64: TLP data beat width.
- c_DRAIN, 2: idle cycles after the eop beat before re-arbitration; legal range 1..15.
- c_TIMEOUT, 1024: maximum GRANT-state cycles waiting for tx_rdy; legal range 2..65535.

- clk  in  1  single clock, all logic rising-edge.
- rstn  in  1  asynchronous active-low reset.
- tx_val  in  1  core transmit valid/credit-OK; new grants are issued only while high.
- tx_req_i  in  4  per-source request, bit n = source n.
- tx_din_0..tx_din_3  in  c_DATA_WIDTH each  source data beats.
- tx_sop_i, tx_eop_i, tx_dwen_i  in  4 each  per-source start, end and dword-enable flags.
- tx_rdy_o  out  4  per-source ready, at most one bit high.
- tx_req  out  1  request to core.
- tx_dout  out  c_DATA_WIDTH  muxed data.
- tx_sop, tx_eop, tx_dwen  out  1 each  muxed flags.
- tx_rdy  in  1  core ready/accept; a beat transfers when tx_rdy=1 in XFER or GRANT.
- gnt  out  2  index of the granted source.
- gnt_vld  out  1  high in GRANT or XFER.
- timeout_err  out  1  one-cycle pulse on grant abort by timeout.

## Operation

- Registered state is: FSM (IDLE, GRANT, XFER, DRAIN), gnt[1:0], priority pointer ptr[1:0], wait counter (16 b), drain counter (4 b), and timeout_err.
- Datapath is combinational from gnt:
  - tx_dout = tx_din_<gnt> always.
  - In GRANT/XFER: tx_req = tx_req_i[gnt], tx_sop/eop/dwen = source gnt's flags, and tx_rdy_o[gnt] = tx_rdy.
  - In IDLE/DRAIN: tx_req, tx_sop, tx_eop, tx_dwen and all tx_rdy_o are 0.
- IDLE:
  - If tx_val=1 and tx_req_i≠0, gnt <= first set bit searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - Clear the wait counter and go to GRANT.
  - Otherwise stay in IDLE.
- GRANT, evaluated in priority order:
  - tx_req_i[gnt]=0 (withdraw): go to IDLE, ptr <= gnt+1.
  - Else tx_rdy=1 with tx_eop_i[gnt]=1 (single-beat packet): go to DRAIN, ptr <= gnt+1.
  - Else tx_rdy=1: go to XFER.
  - Else wait counter = c_TIMEOUT-1: go to IDLE, timeout_err <= 1, ptr <= gnt+1.
  - Else increment the wait counter.
- XFER:
  - Pass-through.
  - tx_rdy=0 stalls the source; the FSM holds.
  - tx_rdy=1 with tx_eop_i[gnt]=1: go to DRAIN, ptr <= gnt+1, drain counter <= 0.
  - No timeout applies in XFER.
- DRAIN: count to c_DRAIN-1, then go to IDLE.
- tx_val falling mid-packet does not abort; it only blocks the next IDLE grant.
- Request changes from non-granted sources have no effect until IDLE.

## Timing

- Reset values: state IDLE, gnt=0, ptr=0, gnt_vld=0, timeout_err=0, tx_req=0, tx_sop=tx_eop=tx_dwen=0, tx_rdy_o=0, and tx_dout=tx_din_0.
- Grant latency: a request sampled in IDLE at edge N gives gnt_vld=1 and tx_req high after edge N (one cycle).
- In GRANT/XFER, tx_rdy to tx_rdy_o[gnt] and source data to tx_dout are zero-latency (combinational).
- After the eop beat is accepted at edge E:
  - DRAIN occupies c_DRAIN cycles.
  - IDLE is reached after edge E+c_DRAIN.
  - The earliest next tx_req is after edge E+c_DRAIN+1.
- Timeout: tx_rdy held low from GRANT entry gives timeout_err high for exactly one cycle, c_TIMEOUT cycles after GRANT entry.
- Asynchronous reset mid-packet forces all reset values immediately; the in-flight packet is discarded.

## Test plan

- Single source: source 2 sends a 3-beat TLP with tx_rdy=1. Expect gnt=2 one cycle after the request, tx_rdy_o=4'b0100 for 3 beats, tx_dout matching tx_din_2, and tx_req=0 for 2 DRAIN cycles.
- Fairness: all four sources request continuously with 1-beat packets. Expect grant order 0,1,2,3,0, with no source granted twice before all others are served.
- Stall: source 1's 4-beat packet has tx_rdy low for 5 cycles mid-packet. Expect the grant held, no timeout_err, and eop accepted last.
- Timeout: c_TIMEOUT=8, source 3 requests and tx_rdy stays 0. Expect timeout_err pulsing once 8 cycles after GRANT entry, return to IDLE, and the next grant going to source 0 if it is requesting.
- Gating and withdraw:
  - tx_val=0 with requests pending: no grant is issued.
  - Source 0 drops tx_req in GRANT: IDLE next cycle, ptr=1.
- Reset: assert rstn low during XFER beat 2. Expect all outputs at reset values immediately, and gnt=0 and ptr=0 after release.
